camera_rgb565_frame_gate: RTL

- Pixel-side front end in the pclk domain that drives the DDR3 pixel writer's pixel/hs/vs inputs directly.
- Takes the raw 8-bit camera bus (two bytes per RGB565 pixel, href/vsync framing) and pairs the bytes into one pixel.
- Expands each pixel to 32-bit ARGB8888 and crops to a fixed H_ACTIVE x V_ACTIVE window.
- Emits a clean frame envelope (vs) and a per-pixel strobe (hs), plus frame/line counters and sticky error flags.

---
 rtl/camera_rgb565_frame_gate.sv | 205 ++++++++++++++++++++
 1 files changed

// File: rtl/camera_rgb565_frame_gate.sv
// Camera front end: pairs RGB565 bytes, expands to ARGB8888, crops to an
// H_ACTIVE x V_ACTIVE window and produces a clean vs envelope with hs strobes.
module camera_rgb565_frame_gate #(
  parameter int         H_ACTIVE  = 1280,
  parameter int         V_ACTIVE  = 720,
  parameter logic [7:0] ALPHA     = 8'hFF,
  parameter bit         VSYNC_POL = 1'b1
) (
  input  logic        pclk,
  input  logic        reset,
  input  logic [7:0]  cam_data,
  input  logic        cam_href,
  input  logic        cam_vsync,
  input  logic        frame_en,
  input  logic        err_clr,
  output logic [31:0] pixel,
  output logic        hs,
  output logic        vs,
  output logic [15:0] frame_count,
  output logic [11:0] line_count,
  output logic        err_short_line,
  output logic        err_odd_bytes,
  output logic        err_short_frame
);

  localparam int PCW = $clog2(H_ACTIVE + 1);

  typedef enum logic [1:0] {ST_SYNC, ST_ARM, ST_ACTIVE, ST_DONE} state_t;

  // Input stage registers and edge-detect history
  logic [7:0] data_q;
  logic       href_q, href_prev_q;
  logic       vsync_act_q, vsync_prev_q;

  state_t         state_q, state_d;
  logic           phase_q, phase_d;
  logic [7:0]     hi_q, hi_d;
  logic [PCW-1:0] pix_cnt_q, pix_cnt_d;
  logic [15:0]    pair_q, pair_d;
  logic           pair_vld_q, pair_vld_d;
  logic [11:0]    line_cnt_q, line_cnt_d;
  logic [15:0]    frame_cnt_q, frame_cnt_d;
  logic           err_short_line_q, err_short_line_d;
  logic           err_odd_bytes_q, err_odd_bytes_d;
  logic           err_short_frame_q, err_short_frame_d;
  logic           hs_q, vs_q;
  logic [31:0]    pixel_q;

  logic        vsync_evt, href_rise, href_fall;
  logic        byte_en;
  logic        set_short_line, set_odd_bytes, set_short_frame;
  logic [31:0] argb;

  assign vsync_evt = vsync_act_q & ~vsync_prev_q;
  assign href_rise = href_q & ~href_prev_q;
  assign href_fall = ~href_q & href_prev_q;

  always_ff @(posedge pclk) begin
    if (reset) begin
      data_q       <= 8'd0;
      href_q       <= 1'b0;
      href_prev_q  <= 1'b0;
      vsync_act_q  <= 1'b0;
      vsync_prev_q <= 1'b0;
    end else begin
      data_q       <= cam_data;
      href_q       <= cam_href;
      href_prev_q  <= href_q;
      vsync_act_q  <= (cam_vsync == VSYNC_POL);
      vsync_prev_q <= vsync_act_q;
    end
  end

  always_ff @(posedge pclk) begin
    if (reset) begin
      state_q           <= ST_SYNC;
      phase_q           <= 1'b0;
      hi_q              <= 8'd0;
      pix_cnt_q         <= '0;
      pair_q            <= 16'd0;
      pair_vld_q        <= 1'b0;
      line_cnt_q        <= 12'd0;
      frame_cnt_q       <= 16'd0;
      err_short_line_q  <= 1'b0;
      err_odd_bytes_q   <= 1'b0;
      err_short_frame_q <= 1'b0;
    end else begin
      state_q           <= state_d;
      phase_q           <= phase_d;
      hi_q              <= hi_d;
      pix_cnt_q         <= pix_cnt_d;
      pair_q            <= pair_d;
      pair_vld_q        <= pair_vld_d;
      line_cnt_q        <= line_cnt_d;
      frame_cnt_q       <= frame_cnt_d;
      err_short_line_q  <= err_short_line_d;
      err_odd_bytes_q   <= err_odd_bytes_d;
      err_short_frame_q <= err_short_frame_d;
    end
  end

  always_comb begin
    state_d         = state_q;
    phase_d         = phase_q;
    hi_d            = hi_q;
    pix_cnt_d       = pix_cnt_q;
    pair_d          = pair_q;
    pair_vld_d      = 1'b0;
    line_cnt_d      = line_cnt_q;
    frame_cnt_d     = frame_cnt_q;
    byte_en         = 1'b0;
    set_short_line  = 1'b0;
    set_odd_bytes   = 1'b0;
    set_short_frame = 1'b0;

    case (state_q)
      ST_SYNC: begin
        if (vsync_evt && frame_en) state_d = ST_ARM;
      end
      ST_ARM: begin
        if (vsync_evt) begin
          if (!frame_en) state_d = ST_SYNC;
        end else if (href_rise) begin
          // The byte that opens the first line is already on data_q; keep it.
          state_d    = ST_ACTIVE;
          line_cnt_d = 12'd0;
          pix_cnt_d  = '0;
          byte_en    = 1'b1;
        end
      end
      ST_ACTIVE: begin
        if (vsync_evt) begin
          set_short_frame = 1'b1;
          phase_d         = 1'b0;
          pix_cnt_d       = '0;
          state_d         = frame_en ? ST_ARM : ST_SYNC;
        end else if (href_fall) begin
          set_odd_bytes  = phase_q;
          set_short_line = (pix_cnt_q < PCW'(H_ACTIVE));
          pix_cnt_d      = '0;
          phase_d        = 1'b0;
          line_cnt_d     = line_cnt_q + 12'd1;
          if (line_cnt_q == 12'(V_ACTIVE - 1)) begin
            frame_cnt_d = frame_cnt_q + 16'd1;
            state_d     = ST_DONE;
          end
        end else if (href_q) begin
          byte_en = 1'b1;
        end
      end
      ST_DONE: begin
        if (vsync_evt) state_d = frame_en ? ST_ARM : ST_SYNC;
      end
      default: state_d = ST_SYNC;
    endcase

    // Byte pairing; pixels past the crop width are paired but never emitted
    if (byte_en) begin
      if (!phase_q) begin
        hi_d    = data_q;
        phase_d = 1'b1;
      end else begin
        phase_d = 1'b0;
        if (pix_cnt_q < PCW'(H_ACTIVE)) begin
          pair_d     = {hi_q, data_q};
          pair_vld_d = 1'b1;
          pix_cnt_d  = pix_cnt_q + PCW'(1);
        end
      end
    end

    // A fresh error event beats a simultaneous clear
    err_short_line_d  = set_short_line  | (err_short_line_q  & ~err_clr);
    err_odd_bytes_d   = set_odd_bytes   | (err_odd_bytes_q   & ~err_clr);
    err_short_frame_d = set_short_frame | (err_short_frame_q & ~err_clr);
  end

  assign argb = {ALPHA,
                 pair_q[15:11], pair_q[15:13],
                 pair_q[10:5],  pair_q[10:9],
                 pair_q[4:0],   pair_q[4:2]};

  // vs follows the state one cycle late so the final pixel of a frame stays inside it
  always_ff @(posedge pclk) begin
    if (reset) begin
      hs_q    <= 1'b0;
      vs_q    <= 1'b0;
      pixel_q <= 32'd0;
    end else begin
      hs_q <= pair_vld_q;
      vs_q <= (state_q == ST_ACTIVE);
      if (pair_vld_q) pixel_q <= argb;
    end
  end

  assign pixel           = pixel_q;
  assign hs              = hs_q;
  assign vs              = vs_q;
  assign frame_count     = frame_cnt_q;
  assign line_count      = line_cnt_q;
  assign err_short_line  = err_short_line_q;
  assign err_odd_bytes   = err_odd_bytes_q;
  assign err_short_frame = err_short_frame_q;

endmodule
